// File: rtl/mem_arbiter.sv
// Serialises fetch and data-port requests onto one single-ported memory with a fixed access
// latency and issues the final dump on halt. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  input  logic        halt,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_dump,
  output logic        busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StAccess = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
  localparam logic [2:0] StDump   = 3'd4;
  localparam logic [2:0] StHalted = 3'd5;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;  // 1 = data port
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_rdata_q, dm_rdata_q;
  logic        grant_dm;
  logic        in_access;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;

  // On a tie the port not served most recently wins.
  assign grant_dm = dm_req & (~if_req | ~last_owner_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner_q <= 1'b0;
    end else if (state_q == StIdle && !halt && (if_req || dm_req)) begin
      last_owner_q <= grant_dm;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StDump;
        end else if (if_req || dm_req) begin
          owner_d = grant_dm;
          wr_d    = grant_dm & dm_wr;
          addr_d  = grant_dm ? dm_addr : if_addr;
          wdata_d = grant_dm ? dm_wdata : 16'h0000;
          if (LATENCY == 1) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      StDump:   state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      if_rdata_q <= 16'h0000;
      dm_rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == StAccess && !wr_q) begin
        if (owner_q) dm_rdata_q <= mem_rdata;
        else         if_rdata_q <= mem_rdata;
      end
    end
  end

  assign in_access = (state_q == StAccess);

  // Enables are gated by reset so a reset landing on an access cycle never writes.
  assign mem_en    = in_access & rst;
  assign mem_wr    = in_access & wr_q & rst;
  assign mem_addr  = in_access ? addr_q : 16'h0000;
  assign mem_wdata = in_access ? wdata_q : 16'h0000;
  assign mem_dump  = (state_q == StDump);

  assign if_done  = (state_q == StDone) & ~owner_q;
  assign dm_done  = (state_q == StDone) & owner_q;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level reference model; a second
// instance exercises LATENCY=1.
module tb_mem_arbiter;

  localparam int unsigned Lat = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, dm_req, dm_wr, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, mem_dump, busy;

  logic        l1_if_req, l1_dm_req, l1_dm_wr, l1_halt;
  logic [15:0] l1_if_addr, l1_dm_addr, l1_dm_wdata;
  logic [15:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_if_done, l1_if_stall, l1_dm_done, l1_dm_stall;
  logic        l1_mem_en, l1_mem_wr, l1_mem_dump, l1_busy;

  mem_arbiter #(.LATENCY(Lat)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .halt(halt), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_dump(mem_dump), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_done(l1_if_done),
    .if_stall(l1_if_stall),
    .dm_req(l1_dm_req), .dm_wr(l1_dm_wr), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_rdata(l1_dm_rdata), .dm_done(l1_dm_done), .dm_stall(l1_dm_stall),
    .halt(l1_halt), .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .mem_dump(l1_mem_dump),
    .busy(l1_busy)
  );

  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(a * 16'h9E37 + 16'h1234);
  endfunction

  // Memory with combinational read and clocked write; contents seeded on the first edge.
  logic [15:0] phys [65536];
  logic        phys_ready = 1'b0;
  always @(posedge clk) begin
    if (!phys_ready) begin
      for (int i = 0; i < 65536; i++) phys[i] <= init_word(16'(i));
      phys_ready <= 1'b1;
    end else if (mem_en && mem_wr) begin
      phys[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata    = phys[mem_addr];
  assign l1_mem_rdata = init_word(l1_mem_addr);

  // Reference model state
  logic [15:0] ref_mem [int];
  logic [15:0] exp_if_rdata, exp_dm_rdata;
  bit          last_dm;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  task automatic model_access(input bit is_dm, input bit wr, input logic [15:0] a,
                              input logic [15:0] wd);
    if (wr) ref_mem[int'(a)] = wd;
    else if (is_dm) exp_dm_rdata = ref_rd(a);
    else exp_if_rdata = ref_rd(a);
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'h0100 + 16'($urandom_range(0, 7));
  endfunction

  task automatic check_rdata();
    check("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
    check("dm_rdata", 32'(dm_rdata), 32'(exp_dm_rdata));
  endtask

  // Per-cycle control check for phase j of an access owned by cur_dm.
  task automatic check_ctl(input string tag, input int j, input bit cur_dm, input bit wr_eff);
    logic [7:0] o, e;
    bit idn, ddn;
    idn = (j == Lat + 1) && !cur_dm;
    ddn = (j == Lat + 1) && cur_dm;
    o = {mem_en, mem_wr, if_done, dm_done, busy, mem_dump, if_stall, dm_stall};
    e = {j == Lat, (j == Lat) && wr_eff, idn, ddn, j > 0, 1'b0, if_req && !idn, dm_req && !ddn};
    check($sformatf("%s ctl c%0d", tag, j), 32'(o), 32'(e));
  endtask

  task automatic run_txn(input bit use_dm, input bit wr, input logic [15:0] a,
                         input logic [15:0] wd, input bit scramble);
    bit wr_eff;
    wr_eff = use_dm && wr;
    if (use_dm) begin
      dm_req = 1'b1; dm_wr = wr; dm_addr = a; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    for (int k = 0; k <= Lat + 1; k++) begin
      @(negedge clk);
      check_ctl("txn", k, use_dm, wr_eff);
      if (k == Lat) begin
        check("txn addr", 32'(mem_addr), 32'(a));
        if (wr_eff) check("txn wdata", 32'(mem_wdata), 32'(wd));
        model_access(use_dm, wr_eff, a, wd);
      end
      @(posedge clk); #1;
      // After grant the port contents are ignored and deassertion does not abort.
      if (scramble && k == 0) begin
        if (use_dm) begin
          dm_addr = 16'($urandom); dm_wdata = 16'($urandom); dm_wr = 1'($urandom);
          dm_req = 1'($urandom_range(0, 1));
        end else begin
          if_addr = 16'($urandom); if_req = 1'($urandom_range(0, 1));
        end
      end
    end
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    last_dm = use_dm;
    check_rdata();
  endtask

  task automatic run_tie();
    bit first_dm, cur_dm, w;
    int j;
    logic [15:0] a_if, a_dm, wd;
    a_if = pick_addr(); a_dm = pick_addr(); w = 1'($urandom); wd = 16'($urandom);
`ifdef MEM_ARB_RR_EN
    first_dm = !last_dm;
`else
    first_dm = 1'b1;
`endif
    if_req = 1'b1; if_addr = a_if;
    dm_req = 1'b1; dm_wr = w; dm_addr = a_dm; dm_wdata = wd;
    for (int k = 0; k <= 2 * Lat + 3; k++) begin
      @(negedge clk);
      j = (k <= Lat + 1) ? k : k - (Lat + 2);
      cur_dm = (k <= Lat + 1) ? first_dm : !first_dm;
      check_ctl("tie", j, cur_dm, cur_dm && w);
      if (j == Lat) begin
        check("tie addr", 32'(mem_addr), 32'(cur_dm ? a_dm : a_if));
        model_access(cur_dm, cur_dm && w, cur_dm ? a_dm : a_if, wd);
      end
      @(posedge clk); #1;
      if (k == Lat + 1) begin
        if (first_dm) dm_req = 1'b0;
        else if_req = 1'b0;
      end
    end
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    last_dm = !first_dm;
    check_rdata();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 32'({if_done, dm_done, if_stall, dm_stall, mem_en, mem_wr, mem_dump,
                              busy}), 32'h0);
    check({tag, " mem"}, {mem_addr, mem_wdata}, 32'h0);
    check({tag, " rdata"}, {if_rdata, dm_rdata}, 32'h0);
  endtask

  initial begin
    rst = 1'b0; halt = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    l1_if_req = 1'b0; l1_if_addr = '0; l1_dm_req = 1'b0; l1_dm_wr = 1'b0;
    l1_dm_addr = '0; l1_dm_wdata = '0; l1_halt = 1'b0;
    exp_if_rdata = '0; exp_dm_rdata = '0; last_dm = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    check("fetch beef", 32'(if_rdata), 32'h0000BEEF);
    run_txn(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    check("dm readback", 32'(dm_rdata), 32'h00001234);
    repeat (4) run_tie();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) run_tie();
      else run_txn(1'($urandom), 1'($urandom), pick_addr(), 16'($urandom), 1'b1);
    end

    // Reset landing on the access cycle of a write.
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h7777;
    for (int k = 0; k < Lat; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    @(negedge clk);
    check("rst access en", 32'({mem_en, mem_wr}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post reset");
    check("no write 0x30", 32'(phys[16'h0030]), 32'(ref_rd(16'h0030)));
    exp_if_rdata = '0; exp_dm_rdata = '0; last_dm = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post reset idle", 32'({if_done, dm_done, busy}), 32'h0);
    end
    @(posedge clk); #1;

    // LATENCY=1 instance: address change after grant must be ignored.
    l1_if_req = 1'b1; l1_if_addr = 16'h0040;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("l1 c%0d", k), 32'({l1_mem_en, l1_if_done, l1_busy}),
            32'({k == 1, k == 2, k == 1 || k == 2}));
      if (k == 1) check("l1 addr", 32'(l1_mem_addr), 32'h0040);
      @(posedge clk); #1;
      if (k == 0) l1_if_addr = 16'h0041;
      if (k == 2) l1_if_req = 1'b0;
    end
    check("l1 rdata", 32'(l1_if_rdata), 32'(init_word(16'h0040)));

    // Halt during WAIT of a data write.
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0050; dm_wdata = 16'hCAFE;
    for (int k = 0; k <= Lat + 10; k++) begin
      logic [7:0] o, e;
      @(negedge clk);
      o = {mem_en, mem_wr, if_done, dm_done, busy, mem_dump, if_stall, dm_stall};
      e = {k == Lat, k == Lat, 1'b0, k == Lat + 1, k > 0 && k != Lat + 2, k == Lat + 3,
           if_req, dm_req && k != Lat + 1};
      check($sformatf("halt c%0d", k), 32'(o), 32'(e));
      @(posedge clk); #1;
      if (k == 0) halt = 1'b1;
      if (k == Lat + 1) begin dm_req = 1'b0; dm_wr = 1'b0; end
      if (k == Lat + 4) begin if_req = 1'b1; if_addr = 16'h0060; end
    end
    check("halt write", 32'(phys[16'h0050]), 32'h0000CAFE);
    if_req = 1'b0; halt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter that shares one single-ported unified memory (memory2c-style: combinational read, write on clock edge) between the fetch stage and the memory stage. It serialises requests, adds a fixed programmable access latency, returns read data with a one-cycle done pulse, and issues the final dump when the processor halts. It sits between the fetch and memory pipeline stages and the memory instance.

## Interface
- LATENCY, 4: cycles from grant to memory access (1..15).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  16  fetch address.
- if_rdata  out  16  fetch read data.
- if_done  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_done.
- dm_req  in  1  data request.
- dm_wr  in  1  1 = write, 0 = read.
- dm_addr  in  16  data address.
- dm_wdata  in  16  write data.
- dm_rdata  out  16  data read data.
- dm_done  out  1  one-cycle data completion pulse.
- dm_stall  out  1  dm_req & ~dm_done.
- halt  in  1  processor halted; request dump.
- mem_en, mem_wr  out  1  memory enable/write.
- mem_addr, mem_wdata  out  16  memory address/write data.
- mem_rdata  in  16  memory read data.
- mem_dump  out  1  memory createdump.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, DONE, DUMP, HALTED.
- IDLE: if halt=1 -> DUMP, no grant. Else if any request: pick owner, latch addr, wr (0 for fetch), wdata; go WAIT with cnt=LATENCY-1, or ACCESS if LATENCY=1.
- WAIT: cnt decrements; cnt==1 -> ACCESS.
- ACCESS: mem_en=1, mem_wr=latched wr, mem_addr/mem_wdata = latched values; on the edge, mem_rdata captured into owner's rdata register (reads only) -> DONE.
- DONE: owner's done=1 for exactly this cycle -> IDLE.
- DUMP: mem_dump=1, mem_en=0 for one cycle -> HALTED.
- HALTED: terminal until reset; no grants, no done; stalls follow requests.
- Arbitration when both request in IDLE: dm wins (default).
- Requests are held by requesters until done; after grant, changes to addr/data/wr are ignored, and deassertion does not abort (done still pulses).
- rdata registers hold their value until the next read completion for that port; writes leave dm_rdata unchanged.
- halt asserted mid-transaction: transaction completes with done, then IDLE -> DUMP.
- mem_* outputs are 0 outside ACCESS/DUMP.

## Timing
- Request visible in IDLE at cycle 0 -> ACCESS in cycle LATENCY, done in cycle LATENCY+1; the next grant is no earlier than cycle LATENCY+2.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Reset: state IDLE, cnt 0, if_rdata/dm_rdata 0, all done/stall/mem_*/busy 0. mem_en/mem_wr are forced to 0 while rst=0, so a reset cycle in ACCESS performs no write; the in-flight transaction is dropped with no done.
- Stall outputs are combinational from req and done.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on ties. A last_owner register records the most recent owner (reset value = fetch, so the first tie goes to data); on a tie, the port that was not last served wins.
- Undefined: fixed data priority, with no last_owner register.

## Test plan
- LATENCY=4, fetch-only read at 0x0010 (memory holds 0xBEEF) -> mem_en high in cycle 4 only, if_done in cycle 5, if_rdata=0xBEEF; if_stall high cycles 0-4.
- dm write 0x1234 to 0x0020, then dm read of 0x0020 -> second access returns dm_rdata=0x1234; dm_rdata unchanged after the write.
- Simultaneous if_req and dm_req held -> dm served first, fetch granted in cycle 6 (LATENCY=4); with MEM_ARB_RR_EN and four repeated ties -> grant order dm, if, dm, if.
- halt raised during WAIT of a dm write -> write completes, dm_done pulses, then mem_dump=1 for exactly one cycle, busy stays 1, later requests get no done.
- rst=0 during ACCESS of a write to 0x0030 -> memory at 0x0030 is unchanged, no done, all outputs 0 the next cycle.
- LATENCY=1 read -> ACCESS in cycle 1, done in cycle 2; address changed after grant -> original address used.
